// File: rtl/player_seq_p.sv
// Player action sequencer: attack, defend and stagger phases
// with a stamina budget, hit resolution and strike/block pulses.
module player_seq_p #(
  parameter int STEPS     = 5,
  parameter int APT_CYC   = 10,
  parameter int ART_CYC   = 2,
  parameter int DHT_CYC   = 20,
  parameter int DRT_CYC   = 1,
  parameter int STG_CYC   = 4,
  parameter int STAM_MAX  = 7,
  parameter int ATK_COST  = 3,
  parameter int REGEN_CYC = 8
) (
  input  logic                             clk_act,
  input  logic                             rst,
  input  logic [1:0]                       act,
  input  logic                             hit,
  output logic [1:0]                       state,
  output logic [2:0]                       phase,
  output logic [$clog2(STEPS+1)-1:0]       led_ctrl,
  output logic                             strike,
  output logic                             blocked,
  output logic [$clog2(STAM_MAX+1)-1:0]    stamina
);

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = mx(mx(mx(APT_CYC, ART_CYC),
                              mx(DHT_CYC, DRT_CYC)),
                           STG_CYC);
  localparam int PW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int LW = $clog2(STEPS+1);
  localparam int SW = $clog2(STAM_MAX+1);
  localparam int RW = (REGEN_CYC > 1) ? $clog2(REGEN_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APREP   = 3'd1,
    ARECOV  = 3'd2,
    DHOLD   = 3'd3,
    DRECOV  = 3'd4,
    STAGGER = 3'd5
  } phase_t;

  phase_t        ph, ph_n;
  logic [PW-1:0] pre, pre_n, lim;
  logic [LW-1:0] step, step_n;
  logic [SW-1:0] stam, stam_n;
  logic [RW-1:0] rc, rc_n;
  logic          strike_n, blocked_n;
  logic          tick, done;

  // Last prescaler value of the current phase.
  always_comb begin
    lim = '0;
    unique case (ph)
      APREP:   lim = PW'(APT_CYC - 1);
      ARECOV:  lim = PW'(ART_CYC - 1);
      DHOLD:   lim = PW'(DHT_CYC - 1);
      DRECOV:  lim = PW'(DRT_CYC - 1);
      STAGGER: lim = PW'(STG_CYC - 1);
      default: lim = '0;
    endcase
  end

  assign tick = (pre == lim);
  assign done = tick && (step == LW'(STEPS - 1));

  // Phase transitions, pulses and stamina bookkeeping.
  always_comb begin
    ph_n      = ph;
    strike_n  = 1'b0;
    blocked_n = 1'b0;
    stam_n    = stam;
    rc_n      = '0;
    unique case (ph)
      IDLE: begin
        if (hit) begin
          ph_n = STAGGER;
        end else if (act[0]) begin
          ph_n = DHOLD;
        end else if (act == 2'b10 &&
                     stam >= SW'(ATK_COST)) begin
          ph_n   = APREP;
          stam_n = stam - SW'(ATK_COST);
        end
      end
      APREP: begin
        if (hit) begin
          ph_n = STAGGER;
        end else if (done) begin
          ph_n     = ARECOV;
          strike_n = 1'b1;
        end
      end
      ARECOV, DRECOV: begin
        if (hit)       ph_n = STAGGER;
        else if (done) ph_n = IDLE;
      end
      DHOLD: begin
        blocked_n = hit;
        if (!act[0] || done) ph_n = DRECOV;
      end
      STAGGER: begin
        if (done) ph_n = IDLE;
      end
      default: ph_n = IDLE;
    endcase
    if (ph == IDLE && ph_n == IDLE &&
        stam != SW'(STAM_MAX)) begin
      if (rc == RW'(REGEN_CYC - 1)) begin
        stam_n = stam + SW'(1);
      end else begin
        rc_n = rc + RW'(1);
      end
    end
  end

  // Step timer; any phase change restarts it.
  always_comb begin
    pre_n  = pre;
    step_n = step;
    if (ph_n != ph || ph == IDLE) begin
      pre_n  = '0;
      step_n = '0;
    end else if (tick) begin
      pre_n  = '0;
      step_n = step + LW'(1);
    end else begin
      pre_n  = pre + PW'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_act) begin
    if (!rst) begin
      ph      <= IDLE;
      pre     <= '0;
      step    <= '0;
      stam    <= SW'(STAM_MAX);
      rc      <= '0;
      strike  <= 1'b0;
      blocked <= 1'b0;
    end else begin
      ph      <= ph_n;
      pre     <= pre_n;
      step    <= step_n;
      stam    <= stam_n;
      rc      <= rc_n;
      strike  <= strike_n;
      blocked <= blocked_n;
    end
  end

  // Legacy two-bit state view of the phase.
  always_comb begin
    state = 2'b00;
    unique case (1'b1)
      (ph == APREP):  state = 2'b10;
      (ph == ARECOV): state = 2'b11;
      (ph == DHOLD):  state = 2'b01;
      default:        state = 2'b00;
    endcase
  end

  assign phase    = ph;
  assign led_ctrl = step;
  assign stamina  = stam;

endmodule
